// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle done pulse, optional auto-reload
module countdown_timer #(
  parameter int WL          = 16,
  parameter bit AUTO_RELOAD = 1'b0,
  parameter int EW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [WL-1:0] ld_val,
  input  logic          cnt_en,
  input  logic          abort,
  output logic [WL-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic [EW-1:0] exp_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WL-1:0] cnt_q, cnt_d, rl_q, rl_d;
  logic [EW-1:0] exp_q, exp_d, exp_inc;
  logic done_q, done_d, zero_ld;
  assign exp_inc = &exp_q ? exp_q : exp_q + 1'b1;
  assign zero_ld = ld_val == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rl_d    = rl_q;
    exp_d   = exp_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (ld_valid) begin
        rl_d    = ld_val;
        cnt_d   = ld_val;
        state_d = zero_ld ? IDLE : RUN;
        done_d  = zero_ld;
        exp_d   = zero_ld ? EW'(1) : '0;
      end
    end else if (abort) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (cnt_en) begin
      // expiry is detected at 1 so the decrement never wraps
      if (cnt_q != WL'(1)) cnt_d = cnt_q - 1'b1;
      else begin
        done_d  = 1'b1;
        exp_d   = exp_inc;
        cnt_d   = AUTO_RELOAD ? rl_q : '0;
        state_d = AUTO_RELOAD ? RUN : IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rl_q    <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rl_q    <= rl_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
    end
  end
  assign ld_ready = state_q == IDLE;
  assign busy     = state_q == RUN;
  assign cnt      = cnt_q;
  assign done     = done_q;
  assign exp_cnt  = exp_q;
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that runs from a loaded value to zero and reports expiry with a one-cycle done pulse.
- It complements the up-counting iteration counter: datapath controllers use it to bound iteration budgets and to time fixed-length waits.
- A valid/ready load port accepts the start value.
- Optional auto-reload mode produces periodic ticks.

Parameters:
WL, 16, width of count and load value.
AUTO_RELOAD, 0, 1 = on expiry reload the last accepted value and keep running; 0 = stop in IDLE.
EW, 8, width of saturating expiry counter exp_cnt.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
ld_valid  input  1  load request.
ld_ready  output  1  load can be accepted; high only in IDLE.
ld_val  input  WL  start value, sampled when ld_valid && ld_ready.
cnt_en  input  1  decrement enable in RUN.
abort  input  1  stop run immediately, no done.
cnt  output  WL  current count, registered.
busy  output  1  high in RUN.
done  output  1  registered one-cycle expiry pulse.
exp_cnt  output  EW  expiries since last accepted load; saturates at 2^EW-1.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, busy=0, done=0, exp_cnt=0, ld_ready=1, internal reload register=0.
  - Reset asserted mid-run forces these values immediately; no done is produced.
- States: IDLE, RUN. busy=(state==RUN); ld_ready=(state==IDLE). Both are decoded from registered state with no input-to-output combinational path.
- done defaults to 0 every cycle unless set by an event below.
- IDLE:
  - If ld_valid && ld_ready at edge N:
    - reload register <= ld_val.
    - exp_cnt <= 0.
    - If ld_val != 0: cnt <= ld_val and state <= RUN. busy is high from cycle N+1.
    - If ld_val == 0 (zero-load boundary): state stays IDLE, cnt <= 0, done=1 in cycle N+1, exp_cnt <= 1.
  - abort and cnt_en are ignored in IDLE. Load + abort in the same IDLE cycle: the load is taken.
- RUN, priority abort > cnt_en:
  - abort=1: cnt <= 0, state <= IDLE, done stays 0, exp_cnt unchanged.
  - cnt_en=0: hold all state.
  - cnt_en=1 and cnt > 1: cnt <= cnt-1.
  - cnt_en=1 and cnt == 1 (expiry):
    - done=1 in the next cycle. exp_cnt <= exp_cnt+1, saturating at 2^EW-1.
    - AUTO_RELOAD=0: cnt <= 0, state <= IDLE. done and cnt==0 are visible in the same cycle.
    - AUTO_RELOAD=1: cnt <= reload register, stay RUN. cnt never displays 0.
  - ld_valid is ignored in RUN because ld_ready=0; the requester must hold ld_valid until accepted.
- Latency:
  - Load of L (L>0) with cnt_en held high gives done exactly L cycles after the load-accept edge.
  - The cnt sequence is L, L-1, ..., 1, then 0 with done.
- Arithmetic:
  - Unsigned WL-bit. Decrement never underflows, because expiry is detected at 1.
  - ld_val = 2^WL-1 is legal and must count fully.
- A new load is accepted in the cycle done is high when AUTO_RELOAD=0, since state is already IDLE, so back-to-back runs have no dead cycle.

Test Plan:
- Reset, then load 5 with cnt_en=1 -> cnt 5,4,3,2,1,0; done high only in the cnt==0 cycle, 5 cycles after accept; busy drops with done; exp_cnt=1.
- Load 4 and toggle cnt_en 1,0,1,0,... -> cnt decrements only on enabled edges; done appears 7 cycles after accept; no early or duplicate done.
- Load 10, run 3 enabled cycles, assert abort with cnt_en=1 -> cnt=0, state IDLE next cycle, done never asserted, ld_ready=1, exp_cnt=0.
- Load 0 -> stays IDLE, done pulses once the next cycle, cnt=0, exp_cnt=1; load of 0xFFFF (WL=16) -> done after 65535 enabled cycles.
- AUTO_RELOAD=1, EW=2, load 3, cnt_en=1 for 15 cycles -> done every 3rd cycle (5 pulses); cnt cycles 3,2,1,3,...; exp_cnt saturates at 3; ld_valid held high is never accepted.
- Assert rst asynchronously mid-run (cnt=7) -> cnt, busy, done, exp_cnt go to 0 without waiting for an edge; after release, a load in the same cycle as done from a prior run is accepted.
